// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_arbiter                                                       |
// | Brief  : Round-robin arbiter sharing one ALU among NUM_REQ requesters.     |
// |          Optional watchdog enabled by defining ALU_ARB_TIMEOUT_EN.         |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+

package calc_pkg;
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_AND  = 2'd3
    } op_t;

    typedef struct packed {
        logic        error;
        logic [15:0] value;
    } num_t;
endpackage

module alu_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  calc_pkg::num_t [NUM_REQ-1:0]   req_left_i,
    input  calc_pkg::num_t [NUM_REQ-1:0]   req_right_i,
    input  calc_pkg::op_t  [NUM_REQ-1:0]   req_op_i,
    input  logic           [NUM_REQ-1:0]   req_valid_i,
    output logic           [NUM_REQ-1:0]   req_ready_o,
    output calc_pkg::num_t                 rsp_result_o,
    output logic           [NUM_REQ-1:0]   rsp_valid_o,
    input  logic           [NUM_REQ-1:0]   rsp_ready_i,
    output calc_pkg::num_t                 alu_left_o,
    output calc_pkg::num_t                 alu_right_o,
    output calc_pkg::op_t                  alu_op_o,
    output logic                           alu_in_valid_o,
    input  logic                           alu_in_ready_i,
    input  calc_pkg::num_t                 alu_result_i,
    input  logic                           alu_out_valid_i,
    output logic                           alu_out_ready_o
);
    import calc_pkg::*;

    localparam int                 c_idx_w    = $clog2(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_idx_w:0]   c_num_req  = (c_idx_w + 1)'(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("alu_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_idx_w-1:0]   owner_q, owner_d;
    logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
    num_t                 left_q, left_d;
    num_t                 right_q, right_d;
    op_t                  op_q, op_d;
    num_t                 rsp_q, rsp_d;

    logic                 w_gnt_found;
    logic [c_idx_w-1:0]   w_gnt_idx;
    logic [c_idx_w:0]     w_sum;
    logic [c_idx_w-1:0]   w_owner_next;
    logic                 w_timeout;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    // Counts cycles spent in the current ISSUE/WAIT visit; any state change restarts it.
    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_ISSUE) || (state_q == S_WAIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_timeout = (cnt_q == c_cnt_last);
`else
    assign w_timeout = 1'b0;
`endif

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_sum       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, rr_ptr_q} + (c_idx_w + 1)'(i);
            if (w_sum >= c_num_req) begin
                w_sum = w_sum - c_num_req;
            end
            if (!w_gnt_found && req_valid_i[w_sum[c_idx_w-1:0]]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_sum[c_idx_w-1:0];
            end
        end
    end

    assign w_owner_next = (owner_q == c_last_idx) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        left_d      = left_q;
        right_d     = right_q;
        op_d        = op_q;
        rsp_d       = rsp_q;
        req_ready_o = '0;
        case (state_q)
            S_IDLE: begin
                if (w_gnt_found) begin
                    req_ready_o[w_gnt_idx] = 1'b1;
                    owner_d = w_gnt_idx;
                    left_d  = req_left_i[w_gnt_idx];
                    right_d = req_right_i[w_gnt_idx];
                    op_d    = req_op_i[w_gnt_idx];
                    if (req_op_i[w_gnt_idx] == OP_NONE) begin
                        rsp_d   = '0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (alu_in_ready_i) begin
                    state_d = S_WAIT;
                end else if (w_timeout) begin
                    rsp_d   = '{error: 1'b1, default: '0};
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (alu_out_valid_i) begin
                    rsp_d   = alu_result_i;
                    state_d = S_RESP;
                end else if (w_timeout) begin
                    rsp_d   = '{error: 1'b1, default: '0};
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i[owner_q]) begin
                    rr_ptr_d = w_owner_next;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= OP_NONE;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            left_q   <= left_d;
            right_q  <= right_d;
            op_q     <= op_d;
            rsp_q    <= rsp_d;
        end
    end

    // Handshake outputs come from state only, keeping ALU/response inputs off these paths.
    always_comb begin
        rsp_valid_o = '0;
        if (state_q == S_RESP) begin
            rsp_valid_o[owner_q] = 1'b1;
        end
    end

    assign alu_in_valid_o  = (state_q == S_ISSUE);
    assign alu_out_ready_o = (state_q == S_WAIT);
    assign alu_left_o      = left_q;
    assign alu_right_o     = right_q;
    assign alu_op_o        = op_q;
    assign rsp_result_o    = rsp_q;

endmodule
`default_nettype wire
